// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and constants for the ALU execution unit.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam int X0 = 0;
    localparam int T1 = 6;
    localparam int A0 = 10;
    localparam int A1 = 11;

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Brief    : Decode-side handshake, operand selects and result bus.
// Revision : 1.0
// ============================================================================
interface alu_exec_unit_if #(
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 32
);
    import alu_pkg::*;

    logic                           valid_in;
    logic                           ready;
    alu_op_t                        ALUctrl;
    logic                           ALUsrc;
    logic [REG_FILE_ADDR_WIDTH-1:0] AD1;
    logic [REG_FILE_ADDR_WIDTH-1:0] AD2;
    logic [REG_FILE_ADDR_WIDTH-1:0] AD3;
    logic                           WE3;
    logic [DATA_WIDTH-1:0]          ImmOp;
    logic [DATA_WIDTH-1:0]          ALUout;
    logic                           EQ;
    logic                           done;
    logic [DATA_WIDTH-1:0]          a0;
    logic [DATA_WIDTH-1:0]          t1;
    logic [DATA_WIDTH-1:0]          a1;

    modport master (
        output valid_in, ALUctrl, ALUsrc, AD1, AD2, AD3, WE3, ImmOp,
        input  ready, ALUout, EQ, done, a0, t1, a1
    );

    modport slave (
        input  valid_in, ALUctrl, ALUsrc, AD1, AD2, AD3, WE3, ImmOp,
        output ready, ALUout, EQ, done, a0, t1, a1
    );

endinterface
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq
// Brief    : Shift-add multiplier, one multiplier bit per cycle, low half kept.
// Revision : 1.0
// ============================================================================
module mul_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_start,
    input  wire logic [DATA_WIDTH-1:0] i_mcand,
    input  wire logic [DATA_WIDTH-1:0] i_mplier,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [DATA_WIDTH-1:0]      o_product
);

    localparam int                c_CW   = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(DATA_WIDTH - 1);

    logic [c_CW-1:0]       r_cnt;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;

    // done marks the cycle whose closing edge performs the final iteration,
    // so the product register is complete immediately after that edge.
    assign o_done    = r_busy && (r_cnt == c_LAST);
    assign o_busy    = r_busy;
    assign o_product = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_acc    <= '0;
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Register file, operand mux, eight-op ALU and sequential MUL.
// Revision : 1.0
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_exec_unit_if.slave bus
);

    localparam int c_NREGS = 2 ** REG_FILE_ADDR_WIDTH;
    localparam int c_SHW   = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]          r_regs [c_NREGS];
    state_t                         r_state;
    state_t                         w_state_next;
    logic [DATA_WIDTH-1:0]          r_aluout;
    logic                           r_eq;
    logic                           r_done;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_ad3;
    logic                           r_we3;

    logic [DATA_WIDTH-1:0]          w_rd1;
    logic [DATA_WIDTH-1:0]          w_op2;
    logic [c_SHW-1:0]               w_shamt;
    logic [DATA_WIDTH-1:0]          w_alu;
    logic [DATA_WIDTH-1:0]          w_result;
    logic [REG_FILE_ADDR_WIDTH-1:0] w_wr_addr;
    logic                           w_wr_en;
    logic                           w_ready;
    logic                           w_accept;
    logic                           w_retire;
    logic                           w_mul_start;
    logic                           w_mul_busy;
    logic                           w_mul_done;
    logic [DATA_WIDTH-1:0]          w_mul_product;

    assign w_rd1    = r_regs[bus.AD1];
    assign w_op2    = bus.ALUsrc ? bus.ImmOp : r_regs[bus.AD2];
    assign w_shamt  = w_op2[c_SHW-1:0];
    assign w_ready  = (r_state == S_IDLE) && !w_mul_busy;
    assign w_accept = bus.valid_in && w_ready;

    always_comb begin
        w_alu = '0;
        case (bus.ALUctrl)
            OP_ADD:  w_alu = w_rd1 + w_op2;
            OP_SUB:  w_alu = w_rd1 - w_op2;
            OP_AND:  w_alu = w_rd1 & w_op2;
            OP_OR:   w_alu = w_rd1 | w_op2;
            OP_XOR:  w_alu = w_rd1 ^ w_op2;
            OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_rd1) < $signed(w_op2))};
            OP_SLL:  w_alu = w_rd1 << w_shamt;
            default: w_alu = '0;
        endcase
    end

    mul_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_mcand   (w_rd1),
        .i_mplier  (w_op2),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // Single-cycle ops retire on their accept edge using live decode fields;
    // MUL retires from WB using the write target captured at accept.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_mul_start  = 1'b0;
        w_result     = w_alu;
        w_wr_en      = bus.WE3;
        w_wr_addr    = bus.AD3;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.ALUctrl == OP_MUL) begin
                        w_mul_start  = 1'b1;
                        w_state_next = S_MUL;
                    end else begin
                        w_retire = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                w_retire     = 1'b1;
                w_result     = w_mul_product;
                w_wr_en      = r_we3;
                w_wr_addr    = r_ad3;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_aluout <= '0;
            r_eq     <= 1'b0;
            r_done   <= 1'b0;
            r_ad3    <= '0;
            r_we3    <= 1'b0;
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_done  <= w_retire;
            if (w_accept) begin
                r_eq  <= (w_rd1 == w_op2);
                r_ad3 <= bus.AD3;
                r_we3 <= bus.WE3;
            end
            if (w_retire) begin
                r_aluout <= w_result;
                if (w_wr_en && (w_wr_addr != '0)) begin
                    r_regs[w_wr_addr] <= w_result;
                end
            end
        end
    end

    assign bus.ready  = w_ready;
    assign bus.ALUout = r_aluout;
    assign bus.EQ     = r_eq;
    assign bus.done   = r_done;
    assign bus.a0     = r_regs[A0];
    assign bus.t1     = r_regs[T1];
    assign bus.a1     = r_regs[A1];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed vector table plus MUL / reset corner sequences.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.REG_FILE_ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    alu_exec_unit #(
        .REG_FILE_ADDR_WIDTH (5),
        .DATA_WIDTH          (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        alu_op_t     op;
        logic        src;
        logic [4:0]  ad1;
        logic [4:0]  ad2;
        logic [4:0]  ad3;
        logic        we3;
        logic [31:0] imm;
        logic [31:0] exp_out;
        logic        exp_eq;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input alu_op_t op, input logic src, input logic [4:0] ad1,
                         input logic [4:0] ad2, input logic [4:0] ad3, input logic we3,
                         input logic [31:0] imm);
        bus.ALUctrl = op;
        bus.ALUsrc  = src;
        bus.AD1     = ad1;
        bus.AD2     = ad2;
        bus.AD3     = ad3;
        bus.WE3     = we3;
        bus.ImmOp   = imm;
    endtask

    function automatic vec_t mk(alu_op_t op, logic src, logic [4:0] ad1, logic [4:0] ad2,
                                logic [4:0] ad3, logic we3, logic [31:0] imm,
                                logic [31:0] exp_out, logic exp_eq);
        vec_t v;
        v.op = op; v.src = src; v.ad1 = ad1; v.ad2 = ad2; v.ad3 = ad3;
        v.we3 = we3; v.imm = imm; v.exp_out = exp_out; v.exp_eq = exp_eq;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        int dones;

        rst          = 1'b1;
        bus.valid_in = 1'b0;
        drive(OP_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        tick;
        tick;
        chk("reset ready", 32'(bus.ready), 32'd1);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset ALUout", bus.ALUout, 32'h0);
        chk("reset EQ", 32'(bus.EQ), 32'd0);
        chk("reset a0", bus.a0, 32'h0);
        chk("reset t1", bus.t1, 32'h0);
        chk("reset a1", bus.a1, 32'h0);
        rst = 1'b0;

        vecs[0]  = mk(OP_ADD, 1, 0,  0,  6,  1, 32'd5,        32'd5,        0);
        vecs[1]  = mk(OP_ADD, 1, 0,  0,  11, 1, 32'hFFFFFFFD, 32'hFFFFFFFD, 0);
        vecs[2]  = mk(OP_SUB, 0, 6,  11, 10, 1, 32'h0,        32'd8,        0);
        vecs[3]  = mk(OP_SLT, 0, 11, 6,  12, 1, 32'h0,        32'd1,        0);
        vecs[4]  = mk(OP_ADD, 1, 12, 0,  13, 1, 32'h0,        32'd1,        0);
        vecs[5]  = mk(OP_ADD, 1, 0,  0,  0,  1, 32'd7,        32'd7,        0);
        vecs[6]  = mk(OP_ADD, 1, 0,  0,  14, 1, 32'h0,        32'h0,        1);
        vecs[7]  = mk(OP_SLL, 1, 6,  0,  15, 1, 32'd33,       32'd10,       0);
        vecs[8]  = mk(OP_ADD, 1, 0,  0,  7,  1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
        vecs[9]  = mk(OP_ADD, 1, 7,  0,  7,  1, 32'd1,        32'h80000000, 0);
        vecs[10] = mk(OP_AND, 0, 11, 6,  16, 1, 32'h0,        32'd5,        0);
        vecs[11] = mk(OP_OR,  0, 11, 6,  17, 1, 32'h0,        32'hFFFFFFFD, 0);
        vecs[12] = mk(OP_XOR, 0, 11, 6,  18, 1, 32'h0,        32'hFFFFFFF8, 0);
        vecs[13] = mk(OP_SLT, 1, 6,  0,  20, 1, 32'hFFFFFFFD, 32'd0,        0);
        vecs[14] = mk(OP_SUB, 0, 6,  6,  19, 0, 32'h0,        32'd0,        1);

        // Back-to-back: valid_in stays high, one new op per cycle.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].src, vecs[i].ad1, vecs[i].ad2, vecs[i].ad3,
                  vecs[i].we3, vecs[i].imm);
            bus.valid_in = 1'b1;
            tick;
            chk($sformatf("vec%0d ALUout", i), bus.ALUout, vecs[i].exp_out);
            chk($sformatf("vec%0d EQ", i), 32'(bus.EQ), 32'(vecs[i].exp_eq));
            chk($sformatf("vec%0d done", i), 32'(bus.done), 32'd1);
            chk($sformatf("vec%0d ready", i), 32'(bus.ready), 32'd1);
        end
        bus.valid_in = 1'b0;
        chk("tap t1", bus.t1, 32'd5);
        chk("tap a1", bus.a1, 32'hFFFFFFFD);
        chk("tap a0", bus.a0, 32'd8);
        tick;
        chk("done idle", 32'(bus.done), 32'd0);

        // MUL 5 * -3 into x10, with a competing op held on valid_in while busy.
        drive(OP_MUL, 1'b0, 5'd6, 5'd11, 5'd10, 1'b1, 32'h0);
        bus.valid_in = 1'b1;
        tick;
        chk("mul accept ready", 32'(bus.ready), 32'd0);
        chk("mul accept EQ", 32'(bus.EQ), 32'd0);
        chk("mul accept done", 32'(bus.done), 32'd0);
        drive(OP_ADD, 1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 32'h55);
        low   = 1;
        dones = 0;
        for (int c = 0; c < 100 && bus.ready == 1'b0; c++) begin
            tick;
            if (bus.done) dones++;
            if (!bus.ready) low++;
        end
        bus.valid_in = 1'b0;
        chk("mul ready-low cycles", 32'(low), 32'd33);
        chk("mul done at retire", 32'(bus.done), 32'd1);
        chk("mul ALUout", bus.ALUout, 32'hFFFFFFF1);
        chk("mul a0", bus.a0, 32'hFFFFFFF1);
        tick;
        if (bus.done) dones++;
        chk("mul done count", 32'(dones), 32'd1);
        chk("mul dropped op no write", bus.a0, 32'hFFFFFFF1);

        // Reset ten cycles into a MUL, with valid_in also asserted under reset.
        drive(OP_MUL, 1'b0, 5'd6, 5'd6, 5'd10, 1'b1, 32'h0);
        bus.valid_in = 1'b1;
        tick;
        bus.valid_in = 1'b0;
        chk("mul2 EQ", 32'(bus.EQ), 32'd1);
        chk("mul2 ready", 32'(bus.ready), 32'd0);
        repeat (9) tick;
        rst = 1'b1;
        drive(OP_ADD, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 32'd9);
        bus.valid_in = 1'b1;
        tick;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        chk("abort ready", 32'(bus.ready), 32'd1);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort ALUout", bus.ALUout, 32'h0);
        chk("abort EQ", 32'(bus.EQ), 32'd0);
        chk("abort a0", bus.a0, 32'h0);
        chk("abort t1", bus.t1, 32'h0);
        chk("abort a1", bus.a1, 32'h0);
        dones = 0;
        repeat (40) begin
            tick;
            if (bus.done) dones++;
        end
        chk("abort no late done", 32'(dones), 32'd0);
        chk("abort no late write", bus.a0, 32'h0);

        drive(OP_ADD, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 32'd5);
        bus.valid_in = 1'b1;
        tick;
        chk("post-reset t1", bus.t1, 32'd5);
        drive(OP_ADD, 1'b1, 5'd6, 5'd0, 5'd5, 1'b1, 32'd5);
        tick;
        bus.valid_in = 1'b0;
        chk("post-reset ALUout", bus.ALUout, 32'd10);
        chk("post-reset EQ", 32'(bus.EQ), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
